regb_load_arbiter: RTL and testbench



---
 rtl/regb_arb_pkg.sv | 29 ++
 rtl/regb_load_arbiter_if.sv | 68 ++++++
 rtl/regb_load_arbiter_rr_pick.sv | 59 +++++
 rtl/regb_load_arbiter.sv | 187 ++++++++++++++++++
 tb/tb_regb_load_arbiter.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/regb_arb_pkg.sv
// ---------------------------------------------------------------------------
// regb_arb_pkg
// Shared types and constants for the register-B load arbiter.
//   arb_state_e  : sequencer states (RUN, DRAIN, HALTED)
//   REGB_LATENCY : load_b -> data_out_b latency of register B
//   STAT_W       : width of each per-requester grant counter
//   id_width()   : requester-ID width, max(1, clog2(n))
// ---------------------------------------------------------------------------
package regb_arb_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } arb_state_e;

    localparam int REGB_LATENCY = 2;
    localparam int STAT_W       = 16;

    // A single requester still needs a 1-bit ID field.
    function automatic int id_width(input int n);
        if (n > 1) begin
            return $clog2(n);
        end else begin
            return 1;
        end
    endfunction

endpackage

// File: rtl/regb_load_arbiter_if.sv
// ---------------------------------------------------------------------------
// regb_load_arbiter_if
// Bundles the requester handshake, the halt/drain handshake, the register-B
// port and the response channel of regb_load_arbiter.
//   slave  : the arbiter's view
//   master : the environment's view (requesters, core, register B)
// Optional macro REGB_ARB_STATS_EN adds grant_count (NUM_REQ x 16 bits).
// ---------------------------------------------------------------------------
interface regb_load_arbiter_if #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REQ    = 4
);
    import regb_arb_pkg::*;

    localparam int ID_W = id_width(NUM_REQ);

    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_ready;
    logic                          halt_req;
    logic                          halted;
    logic                          load_b;
    logic [DATA_WIDTH-1:0]         data_in_b;
    logic [DATA_WIDTH-1:0]         data_out_b;
    logic                          rsp_valid;
    logic [ID_W-1:0]               rsp_id;
    logic [DATA_WIDTH-1:0]         rsp_data;
`ifdef REGB_ARB_STATS_EN
    logic [NUM_REQ*STAT_W-1:0]     grant_count;
`endif

    modport slave (
        input  req_valid,
        input  req_data,
        output req_ready,
        input  halt_req,
        output halted,
        output load_b,
        output data_in_b,
        input  data_out_b,
        output rsp_valid,
        output rsp_id,
        output rsp_data
`ifdef REGB_ARB_STATS_EN
        ,
        output grant_count
`endif
    );

    modport master (
        output req_valid,
        output req_data,
        input  req_ready,
        output halt_req,
        input  halted,
        input  load_b,
        input  data_in_b,
        output data_out_b,
        input  rsp_valid,
        input  rsp_id,
        input  rsp_data
`ifdef REGB_ARB_STATS_EN
        ,
        input  grant_count
`endif
    );

endinterface

// File: rtl/regb_load_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Combinational rotate-priority picker. Searching starts at i_ptr and wraps
// modulo NUM_REQ; the first set request wins.
//   i_req   : request vector
//   i_ptr   : index with highest priority (must be < NUM_REQ)
//   o_grant : one-hot grant (all zero when nothing requested)
//   o_idx   : index of the winner (meaningful only when o_any)
//   o_any   : at least one request present
// ---------------------------------------------------------------------------
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [ID_W-1:0]    i_ptr,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [ID_W-1:0]    o_idx,
    output logic               o_any
);

    logic [NUM_REQ-1:0] w_rot;
    logic [ID_W:0]      w_off;
    logic [ID_W:0]      w_sum;
    logic [ID_W-1:0]    w_idx;

    // Rotate so bit j corresponds to requester (i_ptr + j) mod NUM_REQ.
    assign w_rot = NUM_REQ'({i_req, i_req} >> i_ptr);

    // Lowest set bit of the rotated vector is the nearest requester after i_ptr.
    always_comb begin
        w_off = '0;
        for (int j = NUM_REQ - 1; j >= 0; j--) begin
            w_off = w_rot[j] ? (ID_W+1)'(j) : w_off;
        end
    end

    // Undo the rotation: add the offset back to the pointer, wrapping at NUM_REQ.
    always_comb begin
        w_sum = {1'b0, i_ptr} + w_off;
        if (w_sum >= (ID_W+1)'(NUM_REQ)) begin
            w_idx = ID_W'(w_sum - (ID_W+1)'(NUM_REQ));
        end else begin
            w_idx = ID_W'(w_sum);
        end
    end

    // One-hot decode of the winner.
    always_comb begin
        o_grant = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            o_grant[i] = o_any & (w_idx == ID_W'(i));
        end
    end

    assign o_any = |w_rot;
    assign o_idx = w_idx;

endmodule

// File: rtl/regb_load_arbiter.sv
// ---------------------------------------------------------------------------
// regb_load_arbiter
// Round-robin arbiter and sequencer sharing the register-B load port among
// NUM_REQ requesters. At most one load is granted per cycle; each load is
// tagged with its requester ID and tracked through register B's LATENCY-cycle
// pipeline so the result comes back with the right ID. A halt/drain handshake
// stops new loads and reports when register B is quiescent.
//
// Ports:
//   clk   : single clock, rising edge
//   reset : synchronous, active-high
//   bus   : regb_load_arbiter_if.slave
//           req_valid/req_data/req_ready : requester handshake (ready one-hot)
//           halt_req/halted              : halt/drain handshake
//           load_b/data_in_b/data_out_b  : register-B port
//           rsp_valid/rsp_id/rsp_data    : results, no backpressure
//           grant_count                  : only with REGB_ARB_STATS_EN
//
// Optional macro REGB_ARB_STATS_EN: per-requester saturating 16-bit grant
// counters on bus.grant_count. Undefined: no counters, no port.
//
// req_ready, load_b and data_in_b are combinational from req_valid, rr_ptr,
// state and halt_req; every other output comes from a register.
// ---------------------------------------------------------------------------
module regb_load_arbiter
    import regb_arb_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REQ    = 4,
    parameter int LATENCY    = REGB_LATENCY
) (
    input  logic              clk,
    input  logic              reset,
    regb_load_arbiter_if.slave bus
);

    localparam int ID_W = id_width(NUM_REQ);

    arb_state_e                   r_state;
    arb_state_e                   w_state_nxt;
    logic [ID_W-1:0]              r_rr_ptr;
    logic [ID_W-1:0]              w_ptr_nxt;
    logic [LATENCY-1:0]           r_trk_vld;
    logic [LATENCY-1:0][ID_W-1:0] r_trk_id;
    logic                         r_halted;
    logic                         w_grant_en;
    logic [NUM_REQ-1:0]           w_req_gated;
    logic [NUM_REQ-1:0]           w_grant;
    logic [ID_W-1:0]              w_idx;
    logic                         w_any;
    logic [DATA_WIDTH-1:0]        w_data_in;
    logic                         w_trk_empty;

    // Grants are gated the same cycle halt_req or reset is seen.
    assign w_grant_en  = (r_state == RUN) & ~bus.halt_req & ~reset;
    assign w_req_gated = bus.req_valid & {NUM_REQ{w_grant_en}};

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr_pick (
        .i_req   (w_req_gated),
        .i_ptr   (r_rr_ptr),
        .o_grant (w_grant),
        .o_idx   (w_idx),
        .o_any   (w_any)
    );

    // Route the winning requester's slice to register B (zero when idle).
    always_comb begin
        w_data_in = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_data_in = w_data_in
                      | ({DATA_WIDTH{w_grant[i]}} & bus.req_data[i*DATA_WIDTH +: DATA_WIDTH]);
        end
    end

    // Pointer moves to the requester after the winner, wrapping at NUM_REQ.
    always_comb begin
        if (w_idx == ID_W'(NUM_REQ - 1)) begin
            w_ptr_nxt = '0;
        end else begin
            w_ptr_nxt = w_idx + ID_W'(1);
        end
    end

    assign w_trk_empty = ~|r_trk_vld;

    // Sequencer next state: a drain, once started, always completes.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            RUN: begin
                if (bus.halt_req) begin
                    w_state_nxt = DRAIN;
                end else begin
                    w_state_nxt = RUN;
                end
            end
            DRAIN: begin
                if (w_trk_empty) begin
                    w_state_nxt = HALTED;
                end else begin
                    w_state_nxt = DRAIN;
                end
            end
            HALTED: begin
                if (!bus.halt_req) begin
                    w_state_nxt = RUN;
                end else begin
                    w_state_nxt = HALTED;
                end
            end
            default: begin
                w_state_nxt = RUN;
            end
        endcase
    end

    // Sequencer state register and registered halted flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= RUN;
            r_halted <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_halted <= (w_state_nxt == HALTED);
        end
    end

    // Round-robin pointer advances only on a grant.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rr_ptr <= '0;
        end else if (w_any) begin
            r_rr_ptr <= w_ptr_nxt;
        end else begin
            r_rr_ptr <= r_rr_ptr;
        end
    end

    // In-flight tracker mirrors register B's pipeline; reset drops all tags.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_trk_vld <= '0;
            r_trk_id  <= '0;
        end else begin
            r_trk_vld[0] <= w_any;
            r_trk_id[0]  <= w_any ? w_idx : '0;
            for (int s = 1; s < LATENCY; s++) begin
                r_trk_vld[s] <= r_trk_vld[s-1];
                r_trk_id[s]  <= r_trk_id[s-1];
            end
        end
    end

`ifdef REGB_ARB_STATS_EN
    logic [NUM_REQ-1:0][STAT_W-1:0] r_grant_cnt;

    // Per-requester grant counters, saturating at all-ones.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_grant_cnt <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (w_grant[i] && (r_grant_cnt[i] != {STAT_W{1'b1}})) begin
                    r_grant_cnt[i] <= r_grant_cnt[i] + STAT_W'(1);
                end else begin
                    r_grant_cnt[i] <= r_grant_cnt[i];
                end
            end
        end
    end

    assign bus.grant_count = r_grant_cnt;
`endif

    assign bus.req_ready = w_grant;
    assign bus.load_b    = w_any;
    assign bus.data_in_b = w_data_in;
    assign bus.halted    = r_halted;
    assign bus.rsp_valid = r_trk_vld[LATENCY-1];
    assign bus.rsp_id    = r_trk_id[LATENCY-1];
    // Register B's output is already registered; the result rides along with its tag.
    assign bus.rsp_data  = bus.data_out_b;

endmodule

// File: tb/tb_regb_load_arbiter.sv
// ---------------------------------------------------------------------------
// tb_regb_load_arbiter
// Directed vectors with hand-computed grants; expected responses are queued
// when a grant is expected and popped by an independent monitor whenever the
// DUT presents rsp_valid. Register B is modelled as a 2-stage pipeline.
// ---------------------------------------------------------------------------
module tb_regb_load_arbiter;

    localparam int DW = 32;
    localparam int NR = 4;

    typedef struct {
        logic [1:0]  id;
        logic [31:0] data;
        int          due;
    } exp_t;

    logic        clk;
    logic        reset;
    logic [31:0] td [NR];
    logic [31:0] regb_s0;
    logic [31:0] regb_s1;
    int          cyc_cnt;
    int          vecs;
    int          errs;
    exp_t        q[$];

    regb_load_arbiter_if #(.DATA_WIDTH(DW), .NUM_REQ(NR)) bus ();

    regb_load_arbiter #(
        .DATA_WIDTH (DW),
        .NUM_REQ    (NR),
        .LATENCY    (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        cyc_cnt = 0;
        forever begin
            @(posedge clk);
            cyc_cnt++;
        end
    end

    // Register B model: fixed 2-cycle latency, shares reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            regb_s0 <= 32'd0;
            regb_s1 <= 32'd0;
        end else begin
            regb_s0 <= bus.load_b ? bus.data_in_b : regb_s0;
            regb_s1 <= regb_s0;
        end
    end
    assign bus.data_out_b = regb_s1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc_cnt);
        end
    endtask

    task automatic set_data(input logic [31:0] d0, input logic [31:0] d1,
                            input logic [31:0] d2, input logic [31:0] d3);
        td[0] = d0; td[1] = d1; td[2] = d2; td[3] = d3;
        bus.req_data = {d3, d2, d1, d0};
    endtask

    // One cycle: apply inputs, check combinational/registered outputs mid-cycle.
    task automatic cyc(input logic [3:0] v, input logic h, input logic r,
                       input logic [3:0] exp_rdy, input logic exp_hlt,
                       input logic quiet = 1'b0);
        exp_t e;
        int   gi;
        bus.req_valid = v;
        bus.halt_req  = h;
        reset         = r;
        @(negedge clk);
        check("req_ready", 32'(bus.req_ready), 32'(exp_rdy));
        check("load_b", 32'(bus.load_b), 32'(|exp_rdy));
        check("halted", 32'(bus.halted), 32'(exp_hlt));
        if (quiet) check("rsp_valid_quiet", 32'(bus.rsp_valid), 32'd0);
        gi = -1;
        for (int i = 0; i < NR; i++) begin
            if (exp_rdy[i]) gi = i;
        end
        if (gi >= 0) begin
            check("data_in_b", bus.data_in_b, td[gi]);
            e.id   = 2'(gi);
            e.data = td[gi];
            e.due  = cyc_cnt + 2;
            q.push_back(e);
        end else begin
            check("data_in_b_idle", bus.data_in_b, 32'd0);
        end
        @(posedge clk);
        #1;
        if (r) q.delete();
    endtask

    // Response monitor.
    initial begin : mon
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.rsp_valid === 1'b1) begin
                if (q.size() == 0) begin
                    check("rsp_unexpected", 32'(bus.rsp_valid), 32'd0);
                end else begin
                    e = q.pop_front();
                    check("rsp_id", 32'(bus.rsp_id), 32'(e.id));
                    check("rsp_data", bus.rsp_data, e.data);
                    check("rsp_cycle", 32'(cyc_cnt), 32'(e.due));
                end
            end else if (q.size() != 0 && q[0].due <= cyc_cnt) begin
                e = q.pop_front();
                check("rsp_missing", 32'(bus.rsp_valid), 32'd1);
            end
        end
    end

    initial begin
        vecs = 0;
        errs = 0;
        bus.req_valid = 4'b0000;
        bus.halt_req  = 1'b0;
        reset         = 1'b1;
        set_data(32'h11, 32'h22, 32'h33, 32'h44);

        // Reset with everyone requesting: nothing granted, nothing returned.
        repeat (3) cyc(4'b1111, 1'b0, 1'b1, 4'b0000, 1'b0, 1'b1);

        // All four valid: round robin 0,1,2,3,0.
        cyc(4'b1111, 1'b0, 1'b0, 4'b0001, 1'b0);
        cyc(4'b1111, 1'b0, 1'b0, 4'b0010, 1'b0);
        cyc(4'b1111, 1'b0, 1'b0, 4'b0100, 1'b0);
        cyc(4'b1111, 1'b0, 1'b0, 4'b1000, 1'b0);
        cyc(4'b1111, 1'b0, 1'b0, 4'b0001, 1'b0);
        repeat (3) cyc(4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0);

        // Lone req2 (ptr 1 -> 3), then req1+req3: req3 first, then req1.
        set_data(32'hA0, 32'hA1, 32'hA2, 32'hA3);
        repeat (3) cyc(4'b0100, 1'b0, 1'b0, 4'b0100, 1'b0);
        cyc(4'b1010, 1'b0, 1'b0, 4'b1000, 1'b0);
        cyc(4'b0010, 1'b0, 1'b0, 4'b0010, 1'b0);

        // Halt right after a grant to req1 (ptr 2).
        set_data(32'hB0, 32'hB1, 32'hB2, 32'hB3);
        cyc(4'b0010, 1'b0, 1'b0, 4'b0010, 1'b0);   // t
        cyc(4'b0101, 1'b1, 1'b0, 4'b0000, 1'b0);   // t+1 blocked
        cyc(4'b0101, 1'b1, 1'b0, 4'b0000, 1'b0);   // t+2 rsp id1
        cyc(4'b0101, 1'b1, 1'b0, 4'b0000, 1'b0);   // t+3 tracker empty
        cyc(4'b0101, 1'b1, 1'b0, 4'b0000, 1'b1);   // t+4 halted
        cyc(4'b0101, 1'b0, 1'b0, 4'b0000, 1'b1);   // drop halt while HALTED
        cyc(4'b0101, 1'b0, 1'b0, 4'b0100, 1'b0);   // resume, ptr 2 -> req2
        cyc(4'b0001, 1'b0, 1'b0, 4'b0001, 1'b0);   // ptr 3 -> req0

        // Dropping halt during DRAIN still goes through HALTED.
        cyc(4'b0010, 1'b0, 1'b0, 4'b0010, 1'b0);   // ptr 1 -> req1
        cyc(4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0);
        cyc(4'b0100, 1'b0, 1'b0, 4'b0000, 1'b0);   // DRAIN, rsp in flight
        cyc(4'b0100, 1'b0, 1'b0, 4'b0000, 1'b0);   // DRAIN, empty
        cyc(4'b0100, 1'b0, 1'b0, 4'b0000, 1'b1);   // HALTED
        cyc(4'b0100, 1'b0, 1'b0, 4'b0100, 1'b0);   // RUN, req2
        repeat (3) cyc(4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0);

        // Two loads in flight then reset (ptr 3 before, must return to 0).
        set_data(32'hC0, 32'hC1, 32'hC2, 32'hC3);
        cyc(4'b0110, 1'b0, 1'b0, 4'b0010, 1'b0);   // ptr 3 -> req1
        cyc(4'b0100, 1'b0, 1'b0, 4'b0100, 1'b0);   // req2, ptr -> 3
        cyc(4'b0000, 1'b0, 1'b1, 4'b0000, 1'b0);   // reset pulse
        repeat (3) cyc(4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b1);
        cyc(4'b1001, 1'b0, 1'b0, 4'b0001, 1'b0);   // ptr 0 -> req0
        cyc(4'b1000, 1'b0, 1'b0, 4'b1000, 1'b0);
        repeat (3) cyc(4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0);

`ifdef REGB_ARB_STATS_EN
        cyc(4'b0000, 1'b0, 1'b1, 4'b0000, 1'b0);
        repeat (3) cyc(4'b0010, 1'b0, 1'b0, 4'b0010, 1'b0);
        repeat (3) cyc(4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0);
        check("grant_count0", 32'(bus.grant_count[15:0]), 32'd0);
        check("grant_count1", 32'(bus.grant_count[31:16]), 32'd3);
        check("grant_count2", 32'(bus.grant_count[47:32]), 32'd0);
        check("grant_count3", 32'(bus.grant_count[63:48]), 32'd0);
        repeat (70000) cyc(4'b0001, 1'b0, 1'b0, 4'b0001, 1'b0);
        repeat (3) cyc(4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0);
        check("grant_count0_sat", 32'(bus.grant_count[15:0]), 32'h0000FFFF);
        check("grant_count1_hold", 32'(bus.grant_count[31:16]), 32'd3);
`endif

        check("rsp_queue_left", 32'(q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
